// File: rtl/l2_lru_way_alloc.sv
// l2_lru_way_alloc: per-set LRU age-matrix way allocator with victim locking
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid_i/req_ready_o          access request handshake
//   req_set_i, req_hit_i, req_way_i  set, hit flag and hit way of the access
//   rsp_valid_o/rsp_ready_i          response handshake
//   rsp_set_o, rsp_way_o             response set and hit/victim way
//   rsp_stall_o                      miss found every way locked
//   refill_valid_i, refill_set_i,
//   refill_way_i                     unlock one way when its refill completes
module l2_lru_way_alloc #(
    parameter int NUM_SET   = 16,
    parameter int SET_DEPTH = 4,
    parameter int NUM_WAY   = 4,
    parameter int WAY_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [SET_DEPTH-1:0] req_set_i,
    input  logic                 req_hit_i,
    input  logic [WAY_DEPTH-1:0] req_way_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [SET_DEPTH-1:0] rsp_set_o,
    output logic [WAY_DEPTH-1:0] rsp_way_o,
    output logic                 rsp_stall_o,
    input  logic                 refill_valid_i,
    input  logic [SET_DEPTH-1:0] refill_set_i,
    input  logic [WAY_DEPTH-1:0] refill_way_i
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t               state_q, state_d;
    logic [NUM_WAY-1:0]   age_q  [NUM_SET][NUM_WAY];
    logic [NUM_WAY-1:0]   lock_q [NUM_SET];
    logic [SET_DEPTH-1:0] rsp_set_q;
    logic [WAY_DEPTH-1:0] rsp_way_q, victim, touch_way;
    logic                 rsp_stall_q, found, accept, touch, alloc;
    logic [NUM_WAY-1:0]   free;
    logic [NUM_WAY-1:0]   touch_mask;

    assign rsp_set_o   = rsp_set_q;
    assign rsp_way_o   = rsp_way_q;
    assign rsp_stall_o = rsp_stall_q;

    // A way is the victim when it is unlocked and not more recent than any
    // other unlocked way; descending scan leaves the lowest such index.
    always_comb begin
        free   = ~lock_q[req_set_i];
        victim = '0;
        found  = 1'b0;
        for (int j = NUM_WAY - 1; j >= 0; j--) begin
            if (free[j] && !(|(age_q[req_set_i][j] & free))) begin
                victim = WAY_DEPTH'(j);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
        accept      = req_ready_o && req_valid_i;
        if (accept)
            state_d = RESP;
        else if (rsp_valid_o && rsp_ready_i)
            state_d = IDLE;
        touch      = accept && (req_hit_i || found);
        alloc      = accept && !req_hit_i && found;
        touch_way  = req_hit_i ? req_way_i : victim;
        touch_mask = NUM_WAY'(1) << touch_way;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_set_q   <= '0;
            rsp_way_q   <= '0;
            rsp_stall_q <= 1'b0;
            for (int s = 0; s < NUM_SET; s++) begin
                lock_q[s] <= '0;
                for (int j = 0; j < NUM_WAY; j++)
                    age_q[s][j] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_set_q   <= req_set_i;
                rsp_way_q   <= touch_way;
                rsp_stall_q <= !req_hit_i && !found;
            end
            // Touch: row becomes all ones except the diagonal, column cleared.
            if (touch)
                for (int j = 0; j < NUM_WAY; j++)
                    age_q[req_set_i][j] <= (WAY_DEPTH'(j) == touch_way) ? ~touch_mask
                                                                         : age_q[req_set_i][j] & ~touch_mask;
            // Clear before set so an allocation wins if both hit one bit.
            if (refill_valid_i)
                lock_q[refill_set_i][refill_way_i] <= 1'b0;
            if (alloc)
                lock_q[req_set_i][victim] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l2_lru_way_alloc.sv
// tb_l2_lru_way_alloc: recency-timestamp model plus directed and random stimulus
module tb_l2_lru_way_alloc;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid_i, req_ready_o, req_hit_i;
    logic [3:0] req_set_i, rsp_set_o, refill_set_i;
    logic [1:0] req_way_i, rsp_way_o, refill_way_i;
    logic       rsp_valid_o, rsp_ready_i, rsp_stall_o, refill_valid_i;

    int tests = 0;
    int fails = 0;

    l2_lru_way_alloc dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_set_i(req_set_i), .req_hit_i(req_hit_i), .req_way_i(req_way_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_set_o(rsp_set_o), .rsp_way_o(rsp_way_o), .rsp_stall_o(rsp_stall_o),
        .refill_valid_i(refill_valid_i), .refill_set_i(refill_set_i),
        .refill_way_i(refill_way_i)
    );

    always #5 clk = ~clk;

    // Model: each way remembers when it was last used (0 = never). The victim
    // is the unlocked way with the oldest timestamp, lowest index on a tie.
    int ts   [16][4];
    bit lk   [16][4];
    int tick;
    bit m_valid, m_stall;
    int m_set, m_way;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (ts[s, w]) begin ts[s][w] = 0; lk[s][w] = 0; end
            tick = 0; m_valid = 0; m_stall = 0; m_set = 0; m_way = 0;
        end else begin
            int s, v;
            tick++;
            v = -1;
            s = int'(req_set_i);
            if (!m_valid && req_valid_i) begin
                m_valid = 1; m_set = s;
                if (req_hit_i) begin
                    ts[s][req_way_i] = tick; m_way = int'(req_way_i); m_stall = 0;
                end else begin
                    for (int w = 0; w < 4; w++)
                        if (!lk[s][w] && (v < 0 || ts[s][w] < ts[s][v])) v = w;
                    m_stall = (v < 0);
                    m_way   = (v < 0) ? 0 : v;
                    if (v >= 0) ts[s][v] = tick;
                end
            end else if (m_valid && rsp_ready_i) begin
                m_valid = 0;
            end
            if (refill_valid_i) lk[refill_set_i][refill_way_i] = 0;
            if (v >= 0) lk[s][v] = 1;
        end
    end

    always @(negedge clk) begin
        tests++;
        if (rsp_valid_o !== m_valid || req_ready_o !== !m_valid ||
            (m_valid && (int'(rsp_set_o) != m_set || int'(rsp_way_o) != m_way || rsp_stall_o !== m_stall))) begin
            fails++;
            $display("FAIL cycle_compare t=%0t got valid=%b ready=%b set=%0d way=%0d stall=%b expected valid=%b ready=%b set=%0d way=%0d stall=%b",
                     $time, rsp_valid_o, req_ready_o, rsp_set_o, rsp_way_o, rsp_stall_o,
                     m_valid, !m_valid, m_set, m_way, m_stall);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic req(input int s, input bit h, input int w, input int hold,
                       input bit rf, input int rs, input int rw,
                       output int way, output int stall);
        int n = 0;
        @(negedge clk);
        req_valid_i = 1; req_set_i = 4'(s); req_hit_i = h; req_way_i = 2'(w);
        refill_valid_i = rf; refill_set_i = 4'(rs); refill_way_i = 2'(rw);
        rsp_ready_i = 0;
        @(negedge clk);
        req_valid_i = 0; refill_valid_i = 0;
        while (!rsp_valid_o && n < 10) begin @(negedge clk); n++; end
        if (!rsp_valid_o) begin
            tests++; fails++;
            $display("FAIL rsp_timeout got valid=0 expected valid=1");
            way = -1; stall = -1;
            return;
        end
        way = int'(rsp_way_o); stall = int'(rsp_stall_o);
        repeat (hold) @(negedge clk);
        rsp_ready_i = 1;
        @(negedge clk);
        rsp_ready_i = 0;
    endtask

    task automatic refill(input int s, input int w);
        @(negedge clk);
        refill_valid_i = 1; refill_set_i = 4'(s); refill_way_i = 2'(w);
        @(negedge clk);
        refill_valid_i = 0;
    endtask

    initial begin
        int way, st;
        rst_n = 0; req_valid_i = 0; req_set_i = 0; req_hit_i = 0; req_way_i = 0;
        rsp_ready_i = 0; refill_valid_i = 0; refill_set_i = 0; refill_way_i = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_ready", req_ready_o, 1);
        chk("rst_way", rsp_way_o, 0);
        chk("rst_set", rsp_set_o, 0);
        chk("rst_stall", rsp_stall_o, 0);
        rst_n = 1;

        req(3, 0, 0, 0, 0, 0, 0, way, st); chk("s1_miss_way", way, 0); chk("s1_miss_stall", st, 0);
        refill(3, 0);
        req(3, 0, 0, 0, 0, 0, 0, way, st); chk("s1_miss2_way", way, 1);

        for (int w = 0; w < 4; w++) begin req(5, 1, w, 0, 0, 0, 0, way, st); chk("s2_hit_way", way, w); end
        req(5, 0, 0, 0, 0, 0, 0, way, st); chk("s2_miss_way", way, 0);
        req(5, 1, 0, 0, 0, 0, 0, way, st);
        req(5, 0, 0, 0, 0, 0, 0, way, st); chk("s2_miss2_way", way, 1);

        for (int w = 0; w < 4; w++) begin req(7, 0, 0, 0, 0, 0, 0, way, st); chk("s3_alloc_way", way, w); end
        req(7, 0, 0, 0, 0, 0, 0, way, st); chk("s3_stall", st, 1); chk("s3_stall_way", way, 0);
        refill(7, 2);
        req(7, 0, 0, 0, 0, 0, 0, way, st); chk("s3_after_refill", way, 2); chk("s3_after_refill_stall", st, 0);

        req(1, 1, 3, 5, 0, 0, 0, way, st); chk("s4_hold_way", way, 3);
        @(negedge clk); chk("s4_idle_ready", req_ready_o, 1);

        for (int w = 0; w < 3; w++) begin req(2, 0, 0, 0, 0, 0, 0, way, st); chk("s5_lock_way", way, w); end
        req(2, 0, 0, 0, 1, 2, 0, way, st); chk("s5_concurrent_way", way, 3);
        req(2, 0, 0, 0, 0, 0, 0, way, st); chk("s5_unlocked0", way, 0); chk("s5_unlocked0_stall", st, 0);
        req(2, 0, 0, 0, 0, 0, 0, way, st); chk("s5_all_locked", st, 1);

        @(negedge clk);
        req_valid_i = 1; req_set_i = 1; req_hit_i = 1; req_way_i = 2; rsp_ready_i = 0;
        @(negedge clk);
        req_valid_i = 0;
        chk("s6_in_resp", rsp_valid_o, 1);
        @(posedge clk); #2 rst_n = 0;
        #1 chk("s6_async_drop", rsp_valid_o, 0); chk("s6_async_ready", req_ready_o, 1);
        @(negedge clk); @(negedge clk); rst_n = 1;
        req(7, 0, 0, 0, 0, 0, 0, way, st); chk("s6_post_reset_way", way, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            req_valid_i = 1'($urandom_range(0, 1)); req_set_i = 4'($urandom_range(0, 3));
            req_hit_i = 1'($urandom_range(0, 1)); req_way_i = 2'($urandom);
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            refill_valid_i = ($urandom_range(0, 2) == 0);
            refill_set_i = 4'($urandom_range(0, 3)); refill_way_i = 2'($urandom);
        end
        @(negedge clk);
        req_valid_i = 0; refill_valid_i = 0; rsp_ready_i = 1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
